// File: rtl/bcd_disp_pkg.sv
// Shared types, constants and seven-segment lookup for the BCD display controller.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int         MAX_BCD_VAL = 9999;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles go blank.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/decoder_2x4.sv
// Shared 2-to-4 one-hot decoder (active-high outputs).
module decoder_2x4 (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Double-dabble binary-to-BCD converter feeding a 4-digit multiplexed
// common-anode seven-segment display with leading-zero blanking.
module bcd_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       anode,
  output logic [6:0]       seg
);

  localparam int               CNT_W   = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_BCD_VAL);
  localparam logic [DIV_W-1:0] PRE_TOP = DIV_W'(REFRESH_DIV - 1);

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    for (int n = 0; n < 4; n++) begin
      r[4*n +: 4] = (b[4*n +: 4] >= 4'd5) ? b[4*n +: 4] + 4'd3 : b[4*n +: 4];
    end
    return r;
  endfunction

  state_t           state;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [BIN_W-1:0] sh_bin;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      disp;
  logic [DIV_W-1:0] pre;
  logic [1:0]       idx;
  logic [3:0]       dig_oh;
  logic [3:0]       nib;
  logic             blank;

  always_comb bcd_adj = add3(bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      disp  <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ovf     <= (bin_in > MAX_BIN);
            sh_bin  <= (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
            bcd     <= 16'h0000;
            bit_cnt <= CNT_W'(BIN_W - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd_adj[14:0], sh_bin[BIN_W-1]};
          sh_bin  <= {sh_bin[BIN_W-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) state <= LOAD;
        end
        LOAD: begin
          disp  <= bcd;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running digit scan, independent of the converter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (pre == PRE_TOP) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  decoder_2x4 u_dec (
    .sel    (idx),
    .onehot (dig_oh)
  );

  assign anode = ~dig_oh;

  // Anode and segments both derive from the same registered idx.
  always_comb begin
    nib = disp[{idx, 2'b00} +: 4];
    case (idx)
      2'd1:    blank = (disp[15:4]  == '0);
      2'd2:    blank = (disp[15:8]  == '0);
      2'd3:    blank = (disp[15:12] == '0);
      default: blank = 1'b0;
    endcase
    seg = blank ? SEG_BLANK : seg7(nib);
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Randomized self-checking bench for bcd_display_ctrl with a decimal-arithmetic display model.
module tb_bcd_display_ctrl;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] bin_in = '0;
  logic        start = 1'b0;
  logic        busy, done, ovf;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  int m_disp = 0;
  logic m_ovf = 1'b0;

  bcd_display_ctrl #(.BIN_W(14), .REFRESH_DIV(RD), .DIV_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bin_in (bin_in),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .anode  (anode),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset; the lit digit follows directly from it.
  always @(posedge clk) begin
    if (reset) ticks <= 0;
    else       ticks <= ticks + 1;
  end

  function automatic int cur_idx();
    return (ticks / RD) % 4;
  endfunction

  function automatic logic [3:0] exp_anode();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << cur_idx());
  endfunction

  function automatic logic [6:0] exp_seg(input int v);
    int p, d, n;
    n = cur_idx();
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    if (n > 0 && v < p) return 7'h7F;
    d = (v / p) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (anode !== 4'b1110) begin errors++; $display("FAIL reset_anode got %b want 1110", anode); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset = 1'b0;
    m_disp = 0;
    m_ovf = 1'b0;
  endtask

  task automatic run_conv(input int val, input string name);
    int sat, busy_cnt, done_cnt, done_at, ed;
    sat = (val > 9999) ? 9999 : val;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle got busy=%b want 0", name, busy); end
    bin_in = 14'(val);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int o = 0; o < 20; o++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_at = o; end
      ed = (o >= 15) ? sat : m_disp;
      checks++;
      if (anode !== exp_anode() || seg !== exp_seg(ed)) begin
        errors++;
        $display("FAIL %s_scan o=%0d got anode=%b seg=%b want anode=%b seg=%b", name, o, anode, seg, exp_anode(), exp_seg(ed));
      end
      if (o < 19) tick();
    end
    m_disp = sat;
    m_ovf = (val > 9999);
    checks++; if (busy_cnt != 15) begin errors++; $display("FAIL %s_busy_len got %0d want 15", name, busy_cnt); end
    checks++; if (done_cnt != 1 || done_at != 15) begin errors++; $display("FAIL %s_done got count=%0d at=%0d want count=1 at=15", name, done_cnt, done_at); end
    checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL %s_ovf got %b want %b", name, ovf, m_ovf); end
  endtask

  task automatic test_basic();
    run_conv(1234, "basic_1234");
  endtask

  task automatic test_boundary();
    run_conv(9999, "bnd_9999");
    run_conv(12000, "bnd_12000");
    run_conv(5, "bnd_5");
    run_conv(10000, "bnd_10000");
    run_conv(0, "bnd_0");
    run_conv(16383, "bnd_max");
    run_conv(100, "bnd_100");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_conv(int'($urandom_range(0, 16383)), "rand");
    end
  endtask

  task automatic test_scan_wrap();
    logic [3:0] a0;
    repeat (3) tick();
    a0 = anode;
    repeat (16) tick();
    checks++; if (anode !== a0 || anode !== exp_anode()) begin errors++; $display("FAIL scan_wrap got %b want %b", anode, exp_anode()); end
  endtask

  task automatic test_ignored_and_b2b();
    int first, second, sat2, done_cnt, d1, d2, busy_cnt, ed;
    logic b2b_started, eovf;
    first = 1111;
    second = int'($urandom_range(10000, 16383));
    sat2 = 9999;
    done_cnt = 0; d1 = -1; d2 = -1; busy_cnt = 0; b2b_started = 1'b0;
    bin_in = 14'(first);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int o = 0; o < 36; o++) begin
      if (busy === 1'b1) busy_cnt++;
      if (b2b_started && start) start = 1'b0;
      if (o == 4) begin bin_in = 14'd15000; start = 1'b1; end
      else if (o == 5) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          d1 = o;
          bin_in = 14'(second);
          start = 1'b1;
          b2b_started = 1'b1;
        end else d2 = o;
      end
      ed = (o >= 31) ? sat2 : ((o >= 15) ? first : m_disp);
      eovf = (o >= 16);
      checks++;
      if (anode !== exp_anode() || seg !== exp_seg(ed) || ovf !== eovf) begin
        errors++;
        $display("FAIL ign_b2b o=%0d got anode=%b seg=%b ovf=%b want anode=%b seg=%b ovf=%b", o, anode, seg, ovf, exp_anode(), exp_seg(ed), eovf);
      end
      tick();
    end
    start = 1'b0;
    m_disp = sat2;
    m_ovf = 1'b1;
    checks++; if (done_cnt != 2 || d1 != 15 || d2 != 31) begin errors++; $display("FAIL ign_b2b_done got count=%0d d1=%0d d2=%0d want 2 15 31", done_cnt, d1, d2); end
    checks++; if (busy_cnt != 30) begin errors++; $display("FAIL ign_b2b_busy got %0d want 30", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    bin_in = 14'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (anode !== 4'b1110) begin errors++; $display("FAIL rstmid_anode got %b want 1110", anode); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rstmid_seg got %b want 1000000", seg); end
    reset = 1'b0;
    m_disp = 0;
    m_ovf = 1'b0;
    for (int o = 0; o < 20; o++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      checks++;
      if (anode !== exp_anode() || seg !== exp_seg(0) || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after o=%0d got anode=%b seg=%b busy=%b want %b %b 0", o, anode, seg, busy, exp_anode(), exp_seg(0));
      end
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_nodone got %0d want 0", done_cnt); end
    run_conv(0, "rstmid_zero");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scan_wrap();
    test_boundary();
    test_random();
    test_ignored_and_b2b();
    test_reset_mid();
    test_scan_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
